// File: rtl/sram_controller.sv
// sram_controller: serves 32-bit MEM-stage loads/stores on a 16-bit asynchronous
// SRAM as two half-word phases (low half, then high half), holding the pipeline
// with ready=0 until the full word has been transferred.
module sram_controller #(
  parameter int BASE_ADDR     = 1024,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int HALF_CYCLES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [31:0]              address,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  input  logic [15:0]              sram_dq_in,
  output logic [15:0]              sram_dq_out,
  output logic                     sram_dq_oe,
  output logic                     sram_we_n,
  output logic                     sram_oe_n,
  output logic                     sram_ce_n,
  output logic                     sram_ub_n,
  output logic                     sram_lb_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [31:0] BASE = 32'(BASE_ADDR);
  localparam logic [3:0]  LAST = 4'(HALF_CYCLES - 1);

  state_t                   state;
  state_t                   next_state;
  logic [3:0]               counter;
  logic                     op_write;
  logic [SRAM_ADDR_LEN-2:0] word_lat;
  logic [15:0]              data_hi;

  logic [31:0]              word;
  logic                     request;
  logic                     phase_end;
  logic                     unused_bits;

  // Word index relative to the SRAM base; address[1:0] falls out in the shift.
  assign word        = (address - BASE) >> 2;
  assign request     = wr_en | rd_en;
  assign phase_end   = (counter == LAST);
  assign unused_bits = ^word[31:SRAM_ADDR_LEN-1];

  // Chip enable and byte lanes stay permanently active.
  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic plus the SRAM strobes and the pipeline stall signal.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (state)
      IDLE: begin
        ready = ~request;
        if (request) next_state = LOW;
      end
      LOW, HIGH: begin
        if (op_write) begin
          sram_we_n  = 1'b0;
          sram_dq_oe = 1'b1;
        end else begin
          sram_oe_n = 1'b0;
        end
        if (phase_end) next_state = (state == LOW) ? HIGH : DONE;
      end
      DONE: begin
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latching, phase counter, SRAM address/data registers and load capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter     <= 4'd0;
      op_write    <= 1'b0;
      word_lat    <= '0;
      data_hi     <= 16'h0000;
      read_data   <= 32'h0000_0000;
      sram_addr   <= '0;
      sram_dq_out <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            op_write    <= wr_en;
            word_lat    <= word[SRAM_ADDR_LEN-2:0];
            data_hi     <= write_data[31:16];
            counter     <= 4'd0;
            sram_addr   <= {word[SRAM_ADDR_LEN-2:0], 1'b0};
            sram_dq_out <= write_data[15:0];
          end
        end
        LOW: begin
          if (!op_write && phase_end) read_data[15:0] <= sram_dq_in;
          if (phase_end) begin
            counter     <= 4'd0;
            sram_addr   <= {word_lat, 1'b1};
            sram_dq_out <= data_hi;
          end else begin
            counter <= counter + 4'd1;
          end
        end
        HIGH: begin
          if (!op_write && phase_end) read_data[31:16] <= sram_dq_in;
          if (phase_end) counter <= 4'd0;
          else           counter <= counter + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: drives two controllers (HALF_CYCLES=2 and 1) against
// behavioural SRAMs; expected load results are queued when a request is issued
// and compared when the controller raises ready.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        wr_en_v      [2];
  logic        rd_en_v      [2];
  logic [31:0] address_v    [2];
  logic [31:0] write_data_v [2];
  logic [31:0] read_data_v  [2];
  logic        ready_v      [2];
  logic [17:0] sram_addr_v  [2];
  logic [15:0] dq_in_v      [2];
  logic [15:0] dq_out_v     [2];
  logic        dq_oe_v      [2];
  logic        we_n_v       [2];
  logic        oe_n_v       [2];
  logic        ce_n_v       [2];
  logic        ub_n_v       [2];
  logic        lb_n_v       [2];

  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];

  logic [31:0] ref0 [logic [16:0]];
  logic [31:0] ref1 [logic [16:0]];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd [2];

  int checks;
  int errors;

  sram_controller #(.BASE_ADDR(1024), .SRAM_ADDR_LEN(18), .HALF_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en_v[0]), .rd_en(rd_en_v[0]),
    .address(address_v[0]), .write_data(write_data_v[0]), .read_data(read_data_v[0]),
    .ready(ready_v[0]), .sram_addr(sram_addr_v[0]), .sram_dq_in(dq_in_v[0]),
    .sram_dq_out(dq_out_v[0]), .sram_dq_oe(dq_oe_v[0]), .sram_we_n(we_n_v[0]),
    .sram_oe_n(oe_n_v[0]), .sram_ce_n(ce_n_v[0]), .sram_ub_n(ub_n_v[0]), .sram_lb_n(lb_n_v[0])
  );

  sram_controller #(.BASE_ADDR(1024), .SRAM_ADDR_LEN(18), .HALF_CYCLES(1)) dut_h1 (
    .clk(clk), .rst(rst), .wr_en(wr_en_v[1]), .rd_en(rd_en_v[1]),
    .address(address_v[1]), .write_data(write_data_v[1]), .read_data(read_data_v[1]),
    .ready(ready_v[1]), .sram_addr(sram_addr_v[1]), .sram_dq_in(dq_in_v[1]),
    .sram_dq_out(dq_out_v[1]), .sram_dq_oe(dq_oe_v[1]), .sram_we_n(we_n_v[1]),
    .sram_oe_n(oe_n_v[1]), .sram_ce_n(ce_n_v[1]), .sram_ub_n(ub_n_v[1]), .sram_lb_n(lb_n_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAMs: read data appears while oe_n is low, writes land while we_n is low.
  assign dq_in_v[0] = oe_n_v[0] ? 16'h0000 : mem0[sram_addr_v[0]];
  assign dq_in_v[1] = oe_n_v[1] ? 16'h0000 : mem1[sram_addr_v[1]];

  always @(posedge clk) begin
    if (!we_n_v[0]) mem0[sram_addr_v[0]] <= dq_out_v[0];
    if (!we_n_v[1]) mem1[sram_addr_v[1]] <= dq_out_v[1];
  end

  // Safety net against a hung simulation.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One request on controller d, checked cycle by cycle; entered and left at posedge+1.
  task automatic run_op(input int d, input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] data, input bit perturb, input string name);
    int          h;
    logic [31:0] word;
    logic [17:0] lo;
    logic [17:0] hi;
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    logic [37:0] exp_b;
    logic [37:0] act_b;
    logic        phase_hi;
    h    = (d == 0) ? 2 : 1;
    word = (a - 32'd1024) >> 2;
    lo   = {word[16:0], 1'b0};
    hi   = {word[16:0], 1'b1};
    if (w) begin
      if (d == 0) ref0[word[16:0]] = data;
      else        ref1[word[16:0]] = data;
      exp_rd = last_rd[d];
    end else begin
      if (d == 0) exp_rd = ref0.exists(word[16:0]) ? ref0[word[16:0]] : 32'h0;
      else        exp_rd = ref1.exists(word[16:0]) ? ref1[word[16:0]] : 32'h0;
      last_rd[d] = exp_rd;
    end
    exp_q.push_back(exp_rd);
    wr_en_v[d]      = w;
    rd_en_v[d]      = r;
    address_v[d]    = a;
    write_data_v[d] = data;
    #1;
    checks++;
    if (ready_v[d] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s request-cycle ready: got %b expected 0", name, ready_v[d]);
    end
    for (int c = 1; c <= 2 * h + 1; c++) begin
      @(posedge clk);
      #1;
      if (perturb && c == 1) begin
        address_v[d]    = ~a;
        write_data_v[d] = ~data;
      end
      #1;
      phase_hi = (c > h);
      if (c <= 2 * h) begin
        if (w) exp_b = {1'b0, phase_hi ? hi : lo, 1'b0, 1'b1, 1'b1,
                        phase_hi ? data[31:16] : data[15:0]};
        else   exp_b = {1'b0, phase_hi ? hi : lo, 1'b1, 1'b0, 1'b0, 16'h0000};
      end else begin
        exp_b = {1'b1, hi, 1'b1, 1'b1, 1'b0, 16'h0000};
      end
      act_b = {ready_v[d], sram_addr_v[d], we_n_v[d], oe_n_v[d], dq_oe_v[d],
               (w && c <= 2 * h) ? dq_out_v[d] : 16'h0000};
      checks++;
      if (act_b !== exp_b) begin
        errors++;
        $display("[TB] FAIL %s cycle%0d {ready,addr,we_n,oe_n,dq_oe,dq_out}: got %h expected %h",
                 name, c, act_b, exp_b);
      end
    end
    got_rd = read_data_v[d];
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s scoreboard empty: got %h expected queued value", name, got_rd);
    end else begin
      exp_rd = exp_q.pop_front();
      checks++;
      if (got_rd !== exp_rd) begin
        errors++;
        $display("[TB] FAIL %s read_data: got %h expected %h", name, got_rd, exp_rd);
      end
    end
    @(posedge clk);
    #1;
    wr_en_v[d] = 1'b0;
    rd_en_v[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ready_v[d], we_n_v[d], oe_n_v[d], dq_oe_v[d], ce_n_v[d], ub_n_v[d], lb_n_v[d],
           sram_addr_v[d], dq_out_v[d], read_data_v[d]} !== {4'b1110, 3'b000, 18'h0, 16'h0, 32'h0}) begin
        errors++;
        $display("[TB] FAIL reset_values dut%0d: got ready=%b we_n=%b oe_n=%b oe=%b addr=%h dq=%h rd=%h expected 1,1,1,0,0,0,0",
                 d, ready_v[d], we_n_v[d], oe_n_v[d], dq_oe_v[d], sram_addr_v[d], dq_out_v[d], read_data_v[d]);
      end
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({ready_v[0], we_n_v[0], oe_n_v[0], dq_oe_v[0], sram_addr_v[0]} !== {4'b1110, 18'h0}) begin
        errors++;
        $display("[TB] FAIL idle cycle%0d {ready,we_n,oe_n,dq_oe,addr}: got %b%b%b%b %h expected 1110 0",
                 c, ready_v[0], we_n_v[0], oe_n_v[0], dq_oe_v[0], sram_addr_v[0]);
      end
    end
  endtask

  task automatic test_write_read();
    run_op(0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0, "write_1028");
    run_op(0, 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, "read_1028");
    run_op(0, 1'b0, 1'b1, 32'd1031, 32'h0, 1'b0, "read_1031");
  endtask

  task automatic test_both_set();
    run_op(0, 1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b0, "both_set");
    run_op(0, 1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, "read_after_both");
  endtask

  task automatic test_latch();
    run_op(0, 1'b1, 1'b0, 32'd1036, 32'hCAFEF00D, 1'b1, "latched_write");
    run_op(0, 1'b0, 1'b1, 32'd1038, 32'h0, 1'b1, "latched_read");
  endtask

  task automatic test_wrap();
    run_op(0, 1'b1, 1'b0, 32'd0, 32'hA5A55A5A, 1'b0, "wrap_write");
    run_op(0, 1'b0, 1'b1, 32'd3, 32'h0, 1'b0, "wrap_read");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] data;
    for (int i = 0; i < 4; i++) begin
      a    = 32'd1024 + 32'(4 * (20 + i)) + 32'($urandom_range(0, 3));
      data = $urandom;
      run_op(0, 1'b1, 1'b0, a, data, 1'b0, "rand_write");
    end
    for (int i = 3; i >= 0; i--) begin
      a = 32'd1024 + 32'(4 * (20 + i)) + 32'($urandom_range(0, 3));
      run_op(0, 1'b0, 1'b1, a, 32'h0, 1'b0, "rand_read");
    end
  endtask

  task automatic test_reset_mid();
    wr_en_v[0]      = 1'b1;
    address_v[0]    = 32'd1200;
    write_data_v[0] = 32'h11112222;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if ({we_n_v[0], sram_addr_v[0]} !== {1'b0, 18'd89}) begin
      errors++;
      $display("[TB] FAIL reset_mid pre-reset HIGH phase: got we_n=%b addr=%h expected 0 059",
               we_n_v[0], sram_addr_v[0]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    wr_en_v[0] = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    #1;
    checks++;
    if ({ready_v[0], we_n_v[0], oe_n_v[0], dq_oe_v[0], read_data_v[0], sram_addr_v[0]}
        !== {4'b1110, 32'h0, 18'h0}) begin
      errors++;
      $display("[TB] FAIL reset_mid after reset: got ready=%b we_n=%b oe_n=%b oe=%b rd=%h addr=%h expected 1,1,1,0,0,0",
               ready_v[0], we_n_v[0], oe_n_v[0], dq_oe_v[0], read_data_v[0], sram_addr_v[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({ready_v[0], we_n_v[0], dq_oe_v[0]} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL reset_mid still idle: got ready=%b we_n=%b oe=%b expected 1,1,0",
               ready_v[0], we_n_v[0], dq_oe_v[0]);
    end
    run_op(0, 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, "read_after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(1, 1'b1, 1'b0, 32'd1028, 32'h0BADF00D, 1'b0, "h1_write_a");
    run_op(1, 1'b1, 1'b0, 32'd1032, 32'h600DCAFE, 1'b0, "h1_write_b");
    run_op(1, 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, "h1_read_a");
    run_op(1, 1'b0, 1'b1, 32'd1033, 32'h0, 1'b0, "h1_read_b");
    run_op(1, 1'b0, 1'b1, 32'd1030, 32'h0, 1'b0, "h1_read_a2");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int d = 0; d < 2; d++) begin
      wr_en_v[d]      = 1'b0;
      rd_en_v[d]      = 1'b0;
      address_v[d]    = 32'h0;
      write_data_v[d] = 32'h0;
      last_rd[d]      = 32'h0;
    end
    test_reset();
    test_idle();
    test_write_read();
    test_both_set();
    test_latch();
    test_wrap();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
